// File: rtl/instr_defs.sv
// Shared RISC-V instruction definitions: opcode map and the GPR decode bundle
// carried alongside every queued instruction.
package instr_defs;

  localparam int RegAddrWidth = 5;

  typedef logic [RegAddrWidth-1:0] reg_addr_t;

  typedef enum logic [4:0] {
    LOAD     = 5'b00000,
    MISC_MEM = 5'b00011,
    OP_IMM   = 5'b00100,
    AUIPC    = 5'b00101,
    STORE    = 5'b01000,
    OP       = 5'b01100,
    LUI      = 5'b01101,
    BRANCH   = 5'b11000,
    JALR     = 5'b11001,
    JAL      = 5'b11011,
    SYSTEM   = 5'b11100
  } opcode_e;

  typedef struct packed {
    reg_addr_t rd;
    reg_addr_t rs1;
    reg_addr_t rs2;
    logic      rd_we;
    logic      rs1_re;
    logic      rs2_re;
    logic      illegal;
  } gpr_dec_t;

  // use_m = {rd, rs1, rs2}; an unused address reads as x0
  function automatic gpr_dec_t mk_dec(
    input reg_addr_t  rd,
    input reg_addr_t  rs1,
    input reg_addr_t  rs2,
    input logic [2:0] use_m
  );
    gpr_dec_t d;
    d.rd      = use_m[2] ? rd  : '0;
    d.rs1     = use_m[1] ? rs1 : '0;
    d.rs2     = use_m[0] ? rs2 : '0;
    d.rd_we   = use_m[2];
    d.rs1_re  = use_m[1];
    d.rs2_re  = use_m[0];
    d.illegal = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/riscv_gpr_addr_decode.sv
// Combinational GPR address/enable decode for RV32I and RV32C encodings.
module riscv_gpr_addr_decode
  import instr_defs::*;
(
  input  logic [31:0] instr,
  input  logic        compressed,
  output gpr_dec_t    dec
);

  localparam reg_addr_t X0 = 5'd0;
  localparam reg_addr_t X1 = 5'd1;
  localparam reg_addr_t X2 = 5'd2;

  reg_addr_t r_rd, r_rs1, r_rs2;
  reg_addr_t c_r1, c_r2, c_p1, c_p2;
  opcode_e   opc;
  gpr_dec_t  d;
  logic      ill;
  logic      unused_hi;

  assign r_rd      = instr[11:7];
  assign r_rs1     = instr[19:15];
  assign r_rs2     = instr[24:20];
  assign c_r1      = instr[11:7];
  assign c_r2      = instr[6:2];
  assign c_p1      = {2'b01, instr[9:7]};
  assign c_p2      = {2'b01, instr[4:2]};
  assign opc       = opcode_e'(instr[6:2]);
  assign unused_hi = ^instr[31:25];

  always_comb begin
    d   = '0;
    ill = 1'b0;
    if (!compressed) begin
      if (instr[1:0] != 2'b11) begin
        ill = 1'b1;
      end else begin
        case (opc)
          OP:                  d = mk_dec(r_rd, r_rs1, r_rs2, 3'b111);
          OP_IMM, LOAD, JALR,
          SYSTEM:              d = mk_dec(r_rd, r_rs1, X0, 3'b110);
          STORE, BRANCH:       d = mk_dec(X0, r_rs1, r_rs2, 3'b011);
          LUI, AUIPC, JAL:     d = mk_dec(r_rd, X0, X0, 3'b100);
          MISC_MEM:            d = '0;
          default:             ill = 1'b1;
        endcase
      end
    end else begin
      unique case ({instr[1:0], instr[15:13]})
        5'b00_000: begin
          if (instr[12:5] == 8'd0) ill = 1'b1;
          else d = mk_dec(c_p2, X2, X0, 3'b110);
        end
        5'b00_010: d = mk_dec(c_p2, c_p1, X0, 3'b110);
        5'b00_110: d = mk_dec(X0, c_p1, c_p2, 3'b011);
        5'b01_000: d = mk_dec(c_r1, c_r1, X0, 3'b110);
        5'b01_001: d = mk_dec(X1, X0, X0, 3'b100);
        5'b01_010: d = mk_dec(c_r1, X0, X0, 3'b100);
        5'b01_011: begin
          if ({instr[12], instr[6:2]} == 6'd0) ill = 1'b1;
          else if (c_r1 == X2) d = mk_dec(X2, X2, X0, 3'b110);
          else d = mk_dec(c_r1, X0, X0, 3'b100);
        end
        5'b01_100: begin
          // RV32 has no SUBW/ADDW and no shamt[5]
          if (instr[11:10] == 2'b11) begin
            if (instr[12]) ill = 1'b1;
            else d = mk_dec(c_p1, c_p1, c_p2, 3'b111);
          end else if (!instr[11] && instr[12]) begin
            ill = 1'b1;
          end else begin
            d = mk_dec(c_p1, c_p1, X0, 3'b110);
          end
        end
        5'b01_101: d = '0;
        5'b01_110,
        5'b01_111: d = mk_dec(X0, c_p1, X0, 3'b010);
        5'b10_000: begin
          if (instr[12]) ill = 1'b1;
          else d = mk_dec(c_r1, c_r1, X0, 3'b110);
        end
        5'b10_010: begin
          if (c_r1 == X0) ill = 1'b1;
          else d = mk_dec(c_r1, X2, X0, 3'b110);
        end
        5'b10_100: begin
          if (!instr[12]) begin
            if (c_r2 != X0) d = mk_dec(c_r1, X0, c_r2, 3'b101);
            else if (c_r1 == X0) ill = 1'b1;
            else d = mk_dec(X0, c_r1, X0, 3'b010);
          end else begin
            if (c_r2 != X0) d = mk_dec(c_r1, c_r1, c_r2, 3'b111);
            else if (c_r1 != X0) d = mk_dec(X1, c_r1, X0, 3'b110);
            else d = '0;
          end
        end
        5'b10_110: d = mk_dec(X0, X2, c_r2, 3'b011);
        default:   ill = 1'b1;
      endcase
    end

    if (ill) begin
      d         = '0;
      d.illegal = 1'b1;
    end
    if (d.rd == X0) d.rd_we = 1'b0;
  end

  assign dec = d;

endmodule

// File: rtl/id_decode_queue.sv
// DEPTH-entry decode queue between fetch and register read; entries are
// GPR-decoded on entry so the head carries resolved register addresses.
module id_decode_queue
  import instr_defs::*;
#(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 2,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [XLEN-1:0]       in_pc,
  input  logic                  in_compressed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instr,
  output logic [XLEN-1:0]       out_pc,
  output logic                  out_compressed,
  output logic [REG_ADDR_W-1:0] out_rd_addr,
  output logic [REG_ADDR_W-1:0] out_rs1_addr,
  output logic [REG_ADDR_W-1:0] out_rs2_addr,
  output logic                  out_rd_we,
  output logic                  out_rs1_re,
  output logic                  out_rs2_re,
  output logic                  out_illegal
);

  localparam int PtrW = $clog2(DEPTH);
  localparam int CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic            compressed;
    gpr_dec_t        dec;
  } entry_t;

  entry_t            mem_q [DEPTH];
  entry_t            mem_d [DEPTH];
  logic [PtrW-1:0]   wptr_q, wptr_d;
  logic [PtrW-1:0]   rptr_q, rptr_d;
  logic [CntW-1:0]   count_q, count_d;
  gpr_dec_t          in_dec;
  entry_t            wr_entry;
  entry_t            head;
  logic              push, pop;

  riscv_gpr_addr_decode u_dec (
    .instr      (in_instr),
    .compressed (in_compressed),
    .dec        (in_dec)
  );

  assign wr_entry = '{
    instr:      in_instr,
    pc:         in_pc,
    compressed: in_compressed,
    dec:        in_dec
  };

  assign in_ready  = (count_q != Full);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[wptr_q] = wr_entry;
        wptr_d        = wptr_q + PtrW'(1);
      end
      if (pop) rptr_d = rptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign head           = mem_q[rptr_q];
  assign out_instr      = head.instr;
  assign out_pc         = head.pc;
  assign out_compressed = head.compressed;
  assign out_rd_addr    = REG_ADDR_W'(head.dec.rd);
  assign out_rs1_addr   = REG_ADDR_W'(head.dec.rs1);
  assign out_rs2_addr   = REG_ADDR_W'(head.dec.rs2);
  assign out_rd_we      = head.dec.rd_we;
  assign out_rs1_re     = head.dec.rs1_re;
  assign out_rs2_re     = head.dec.rs2_re;
  assign out_illegal    = head.dec.illegal;

endmodule
